// File: rtl/ittage_bank_sram_ctrl.sv
// RW0 port controller for the 128x76 ITTAGE bank SRAM: zeroing sweep after reset, then
// write-priority arbitration of read/write requests. Read-starvation guard: ITTAGE_SRAM_RD_STARVE_EN.
module ittage_bank_sram_ctrl #(
  parameter int DEPTH        = 128,
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 76,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_mask,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [DATA_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  // state   | meaning
  // ST_INIT | zeroing sweep, one entry per cycle, requests blocked
  // ST_RUN  | arbitrating requests onto the single port
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [DATA_W-1:0] hold_q;
  logic              force_rd;
  logic              rd_fire, wr_fire;

  assign rd_fire   = rd_req_valid & rd_req_ready;
  assign wr_fire   = wr_req_valid & wr_req_ready;
  assign init_done = (state == ST_RUN);

`ifdef ITTAGE_SRAM_RD_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_cnt;

  assign force_rd = (state == ST_RUN) && (starve_cnt == SC_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (rd_fire) begin
      starve_cnt <= '0;
    end else if ((state == ST_RUN) && rd_req_valid && wr_fire && (starve_cnt != SC_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign force_rd = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    rd_req_ready = 1'b0;
    wr_req_ready = 1'b0;
    sram_en      = 1'b0;
    sram_wmode   = 1'b0;
    sram_addr    = rd_req_addr;
    sram_wmask   = '0;
    sram_wdata   = '0;
    case (state)
      ST_INIT: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_cnt;
        sram_wmask = '1;
        if (init_cnt == LAST_ADDR) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        wr_req_ready = !force_rd;
        rd_req_ready = force_rd | !wr_req_valid;
        if (wr_req_valid && !force_rd) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = wr_req_addr;
          sram_wmask = wr_req_mask;
          sram_wdata = wr_req_data;
        end else if (rd_req_valid) begin
          sram_en = 1'b1;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // The array presents read data for a single cycle; the hold register keeps it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_valid <= 1'b0;
      hold_q        <= '0;
    end else begin
      rd_resp_valid <= rd_fire;
      if (rd_resp_valid) hold_q <= sram_rdata;
    end
  end

  assign rd_resp_data = rd_resp_valid ? sram_rdata : hold_q;

endmodule

// File: tb/tb_ittage_bank_sram_ctrl.sv
// Bench for ittage_bank_sram_ctrl: behavioural RW0 array, reference memory and read scoreboard.
module tb_ittage_bank_sram_ctrl;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 76;
  localparam logic [DATA_W-1:0] D1 = 76'h1234_5678_9ABC_DEF0_123;
  localparam logic [DATA_W-1:0] D2 = 76'hA5A5_0F0F_3C3C_7E7E_E1E;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rd_req_valid, rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_req_valid, wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_mask, wr_req_data;
  logic              init_done;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en, sram_wmode;
  logic [DATA_W-1:0] sram_wmask, sram_wdata, sram_rdata;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q   [$];
  logic              rd_fired_prev;
  logic [DATA_W-1:0] exp_hold;
  int n_checks = 0;
  int n_pass   = 0;

  ittage_bank_sram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_mask(wr_req_mask), .wr_req_data(wr_req_data),
    .init_done(init_done),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Array model; rdata is scrambled outside read-response cycles so the hold path is exercised.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '1;
      ref_mem[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (sram_en && sram_wmode)
      mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
    if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
    else sram_rdata <= 76'({$urandom(), $urandom(), $urandom()});
  end

  // Scoreboard: inputs are driven just after posedge, so the negedge sees stable fires.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      rd_fired_prev = 1'b0;
    end else begin
      if (rd_fired_prev && !rd_resp_valid) check("resp_missing", 76'(rd_resp_valid), 76'(1));
      if (rd_resp_valid) begin
        if (exp_q.size() == 0) check("resp_unexpected", 76'(rd_resp_valid), 76'(0));
        else check("rd_resp_data", rd_resp_data, exp_q.pop_front());
      end
      rd_fired_prev = rd_req_valid && rd_req_ready;
      if (rd_fired_prev) exp_q.push_back(ref_mem[rd_req_addr]);
      if (wr_req_valid && wr_req_ready)
        ref_mem[wr_req_addr] = (ref_mem[wr_req_addr] & ~wr_req_mask) | (wr_req_data & wr_req_mask);
    end
  end

  // Tasks start and end just after a posedge so consecutive calls are back-to-back.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] m,
                          input logic [DATA_W-1:0] d);
    bit fired = 0;
    wr_req_valid = 1'b1; wr_req_addr = a; wr_req_mask = m; wr_req_data = d;
    for (int k = 0; k < 20 && !fired; k++) begin
      @(negedge clk);
      fired = wr_req_ready;
      @(posedge clk); #1;
    end
    if (!fired) check("wr_timeout", 76'(fired), 76'(1));
    wr_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    bit fired = 0;
    rd_req_valid = 1'b1; rd_req_addr = a;
    for (int k = 0; k < 20 && !fired; k++) begin
      @(negedge clk);
      fired = rd_req_ready;
      @(posedge clk); #1;
    end
    if (!fired) check("rd_timeout", 76'(fired), 76'(1));
    rd_req_valid = 1'b0;
  endtask

  task automatic check_sweep_cycle(input int i);
    check("init_addr",  76'(sram_addr),  76'(i));
    check("init_en",    76'(sram_en),    76'(1));
    check("init_wmode", 76'(sram_wmode), 76'(1));
    check("init_wdata", sram_wdata, '0);
    check("init_wmask", sram_wmask, '1);
    check("init_done_low", 76'(init_done), 76'(0));
    check("init_wr_ready", 76'(wr_req_ready), 76'(0));
    check("init_rd_ready", 76'(rd_req_ready), 76'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rd_req_valid = 1'b0; rd_req_addr = '0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_mask = '0; wr_req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", 76'(init_done), 76'(0));
    check("rst_rd_ready", 76'(rd_req_ready), 76'(0));
    check("rst_wr_ready", 76'(wr_req_ready), 76'(0));
    check("rst_resp_valid", 76'(rd_resp_valid), 76'(0));
    check("rst_resp_data", rd_resp_data, '0);

    // Partial sweep with a write pending, then reset at init_cnt=40.
    rst_n = 1'b1;
    wr_req_valid = 1'b1; wr_req_addr = 7'd9; wr_req_mask = '1; wr_req_data = D2;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      check_sweep_cycle(i);
    end
    rst_n = 1'b0;
    wr_req_valid = 1'b0;
    #1;
    check("midinit_rst_done", 76'(init_done), 76'(0));
    check("midinit_rst_addr", 76'(sram_addr), 76'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check_sweep_cycle(i);
    end
    @(negedge clk);
    check("init_done_high", 76'(init_done), 76'(1));
    check("idle_en", 76'(sram_en), 76'(0));
    check("run_wr_ready", 76'(wr_req_ready), 76'(1));
    check("run_rd_ready", 76'(rd_req_ready), 76'(1));
    @(posedge clk); #1;

    do_read(7'h55);
    do_write(7'd3, '1, D1);
    do_read(7'd3);
    do_write(7'd3, 76'hFF, '1);
    do_read(7'd3);
    do_read(7'd3);
    do_read(7'h55);
    do_read(7'd3);
    do_write(7'd20, 76'h0, D2);
    do_read(7'd20);

    // Conflict: write wins, read follows next cycle, then the response must hold.
    wr_req_valid = 1'b1; wr_req_addr = 7'd5; wr_req_mask = '1; wr_req_data = D2;
    rd_req_valid = 1'b1; rd_req_addr = 7'd3;
    @(negedge clk);
    check("conf_rd_ready", 76'(rd_req_ready), 76'(0));
    check("conf_wr_ready", 76'(wr_req_ready), 76'(1));
    check("conf_wmode", 76'(sram_wmode), 76'(1));
    check("conf_waddr", 76'(sram_addr), 76'(5));
    @(posedge clk); #1 wr_req_valid = 1'b0;
    @(negedge clk);
    check("conf_rd_ready2", 76'(rd_req_ready), 76'(1));
    check("conf_rmode", 76'(sram_wmode), 76'(0));
    check("conf_raddr", 76'(sram_addr), 76'(3));
    @(posedge clk); #1 rd_req_valid = 1'b0;
    @(negedge clk);
    exp_hold = ref_mem[3];
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_valid", 76'(rd_resp_valid), 76'(0));
      check("hold_data", rd_resp_data, exp_hold);
    end
    @(posedge clk); #1;
    do_read(7'd5);

    // Both requests held high: read forced after four writes only with the guard enabled.
    wr_req_valid = 1'b1; wr_req_addr = 7'd10; wr_req_mask = '1; wr_req_data = D1;
    rd_req_valid = 1'b1; rd_req_addr = 7'd3;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef ITTAGE_SRAM_RD_STARVE_EN
      check("starve_wr_ready", 76'(wr_req_ready), 76'(k != 4));
      check("starve_rd_ready", 76'(rd_req_ready), 76'(k == 4));
`else
      check("starve_wr_ready", 76'(wr_req_ready), 76'(1));
      check("starve_rd_ready", 76'(rd_req_ready), 76'(0));
`endif
      @(posedge clk); #1;
    end
    wr_req_valid = 1'b0;
    @(negedge clk);
    check("starve_end_rd_ready", 76'(rd_req_ready), 76'(1));
    @(posedge clk); #1 rd_req_valid = 1'b0;
    @(negedge clk);
    do_read(7'd10);

    // Reset with a response in flight: it is dropped and the hold register cleared.
    @(posedge clk); #1;
    rd_req_valid = 1'b1; rd_req_addr = 7'd3;
    @(posedge clk); #2;
    rst_n = 1'b0;
    rd_req_valid = 1'b0;
    #1;
    check("rst_inflight_valid", 76'(rd_resp_valid), 76'(0));
    check("rst_inflight_data", rd_resp_data, '0);
    check("rst_inflight_done", 76'(init_done), 76'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_restart_addr", 76'(sram_addr), 76'(0));
    check("rst_restart_resp", 76'(rd_resp_valid), 76'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
